serial_subtractor_4bit: RTL and testbench
=========================================

SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; the values in this document assume WIDTH=4.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  minuend; captured at the accepted start.
REQ-006 Port: B  input  WIDTH  subtrahend; captured at the accepted start.
REQ-007 Port: Bin  input  1  borrow-in; captured at the accepted start.
REQ-008 Port: Diff  output  WIDTH  registered result, A - B - Bin modulo 2^WIDTH.
REQ-009 Port: Bout  output  1  registered borrow-out; 1 when A < B + Bin (unsigned).
REQ-010 Port: V  output  1  registered signed two's-complement overflow flag.
REQ-011 Port: Z  output  1  registered zero flag; 1 when Diff == 0.
REQ-012 Port: busy  output  1  high while the subtraction is in progress (SHIFT state).
REQ-013 Port: done  output  1  one-cycle pulse marking a valid, newly updated result.

Function
REQ-014 The block SHALL implement an FSM with three states: IDLE, SHIFT and DONE.
REQ-015 IDLE with start=1 at an edge: capture A, B and Bin into internal registers, clear the bit counter, and go to SHIFT.
REQ-016 IDLE with start=0: remain in IDLE.
REQ-017 In SHIFT, each edge SHALL process one bit i, LSB first, with a registered borrow br initialised from Bin.
REQ-018 The per-bit difference SHALL be d = a^b^br, written into bit i of an internal result register.
REQ-019 The next borrow SHALL be br' = (~a&b) | (~a&br) | (b&br).
REQ-020 On the edge that processes bit WIDTH-1, the FSM SHALL go to DONE and load Diff, Bout, V and Z from the completed result in the same edge.
REQ-021 Bout SHALL equal the final borrow br'.
REQ-022 V SHALL equal (A[MSB]^B[MSB]) & (Diff[MSB]^A[MSB]), computed on the captured operands.
REQ-023 Z SHALL equal the NOR of all Diff bits.
REQ-024 DONE SHALL last exactly one cycle with done=1 and then return to IDLE unconditionally.
REQ-025 Latency: if start is sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-026 busy SHALL be 1 exactly in SHIFT, i.e. for WIDTH cycles per operation.
REQ-027 start SHALL be ignored in SHIFT and DONE.
REQ-028 Changes on A, B or Bin after capture SHALL have no effect on the operation in progress.
REQ-029 Diff, Bout, V and Z SHALL change only on the edge entering DONE, and hold their values until the next completion or reset.
REQ-030 Back-to-back operation: start sampled in the first IDLE cycle after DONE SHALL be accepted; the minimum period is WIDTH+2 cycles.

Reset
REQ-031 With rst=1 at an edge, the FSM SHALL go to IDLE and Diff, Bout, V, Z, busy, done, the bit counter, br and the captured operands SHALL all become 0.
REQ-032 rst SHALL take priority over start and over any state transition.
REQ-033 A reset during SHIFT SHALL discard the operation in progress, with no done pulse and no result update.
REQ-034 After reset deasserts, the first start sampled in IDLE SHALL be accepted normally.

Verification
REQ-035 Basic case: A=7, B=3, Bin=0, start pulse -> busy high for 4 cycles, then done pulse with Diff=4, Bout=0, V=0, Z=0.
REQ-036 Borrow case: A=3, B=7, Bin=0 -> Diff=12, Bout=1, V=0, Z=0.
REQ-037 Signed overflow: A=8, B=1, Bin=0 -> Diff=7, Bout=0, V=1, Z=0.
REQ-038 Zero with Bin: A=5, B=4, Bin=1 -> Diff=0, Z=1, Bout=0.
REQ-039 Wrap-around: A=0, B=15, Bin=1 -> Diff=0, Z=1, Bout=1, V=0.
REQ-040 start held high during busy with A and B changed -> result matches the captured operands; a second start in the cycle after done -> accepted, done 4 cycles later.
REQ-041 rst=1 in the second SHIFT cycle -> next cycle busy=0, done=0, and all outputs 0; no done pulse follows.

Source files
------------

// File: rtl/serial_subtractor_4bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_4bit
//
// Bit-serial unsigned subtractor. A start in IDLE captures A, B and Bin. The
// block then handles one bit per clock, LSB first, for WIDTH clocks (SHIFT)
// and keeps a running borrow. On the last bit it loads the registered result
// and flags. It then gives a one-cycle done pulse (DONE) and returns to IDLE.
//
// Ports
//   clk   : clock; all state updates on the rising edge
//   rst   : synchronous, active-high reset (clears state, operands, results)
//   start : begin one subtraction; only looked at in IDLE
//   A, B  : minuend / subtrahend, captured at the accepted start
//   Bin   : borrow-in, captured at the accepted start
//   Diff  : registered A - B - Bin modulo 2^WIDTH
//   Bout  : registered borrow-out (A < B + Bin, unsigned)
//   V     : registered two's-complement overflow flag
//   Z     : registered zero flag (Diff == 0)
//   busy  : high for the WIDTH cycles spent in SHIFT
//   done  : one-cycle pulse when Diff/Bout/V/Z have just been updated
// ---------------------------------------------------------------------------
module serial_subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             V,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt;
  logic             abit, bbit, dbit;
  logic             last;

  // Subtraction overflow: operands of opposite sign, and the result's sign
  // differs from the minuend's.
  function automatic logic sub_ovf(input logic am, input logic bm, input logic dm);
    return (am ^ bm) & (dm ^ am);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One full-subtractor cell, applied to the bit picked by cnt. res_nxt is
  // the result with the current bit merged in. On the last bit Diff loads
  // this value, so the complete result is available on the same edge.
  always_comb begin
    abit    = a_r[cnt];
    bbit    = b_r[cnt];
    dbit    = abit ^ bbit ^ br;
    br_nxt  = (~abit & bbit) | (~abit & br) | (bbit & br);
    res_nxt = res;
    res_nxt[cnt] = dbit;
    last    = (cnt == LAST);
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      res  <= '0;
      Diff <= '0;
      Bout <= 1'b0;
      V    <= 1'b0;
      Z    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= A;
            b_r <= B;
            br  <= Bin;
            cnt <= '0;
            res <= '0;
          end
        end
        SHIFT: begin
          res <= res_nxt;
          br  <= br_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            Diff <= res_nxt;
            Bout <= br_nxt;
            V    <= sub_ovf(a_r[WIDTH-1], b_r[WIDTH-1], res_nxt[WIDTH-1]);
            Z    <= ~|res_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
module tb_serial_subtractor_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, Bin;
  logic [W-1:0] A, B;
  logic [W-1:0] Diff;
  logic         Bout, V, Z, busy, done;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .Diff(Diff), .Bout(Bout), .V(V), .Z(Z), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout, v, z;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  exp_t         got;
  int           n_cmp = 0, n_bad = 0;
  int           cyc = 0;
  int           busy_run = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] h_diff = '0;
  logic         h_bout = 1'b0, h_v = 1'b0, h_z = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int a, input int b, input int bin);
    exp_t e;
    int   d, sa, sb, sd;
    d      = a - b - bin;
    e.diff = W'(d);
    e.bout = (a < b + bin);
    sa     = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb     = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    sd     = sa - sb - bin;
    e.v    = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
    e.z    = (e.diff == '0);
    e.cyc  = 0;
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done pulse; otherwise results must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          got = q.pop_front();
          chk("done_cycle", cyc, got.cyc);
          chk("Diff", Diff, got.diff);
          chk("Bout", Bout, got.bout);
          chk("V", V, got.v);
          chk("Z", Z, got.z);
          chk("busy_len", busy_run, W);
          h_diff = got.diff; h_bout = got.bout; h_v = got.v; h_z = got.z;
        end
        busy_run = 0;
      end else begin
        chk("hold", {Diff, Bout, V, Z}, {h_diff, h_bout, h_v, h_z});
        if (busy) busy_run++;
        else      busy_run = 0;
      end
    end
  end

  // Issue one operation. During SHIFT/DONE the operands are scrambled, and
  // start is optionally held high; neither may affect the result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input bit hold);
    exp_t e;
    @(negedge clk);
    start = 1'b1; A = a; B = b; Bin = bin;
    @(posedge clk); #1;
    e = model(int'(a), int'(b), int'(bin));
    e.cyc = cyc + W;
    q.push_back(e);
    repeat (W + 1) begin
      @(negedge clk);
      start = hold;
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
    end
  endtask

  // Start an operation, then reset in its second SHIFT cycle.
  task automatic reset_mid(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clk);
    start = 1'b1; A = a; B = b; Bin = bin;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    h_diff = '0; h_bout = 1'b0; h_v = 1'b0; h_z = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out", {Diff, Bout, V, Z}, '0);
    rst = 1'b0;
    idle(W + 2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_busy", busy, 1'b0);
    chk("init_done", done, 1'b0);
    chk("init_out", {Diff, Bout, V, Z}, '0);
    rst = 1'b0;
    mon_en = 1'b1;

    issue(4'd7, 4'd3, 1'b0, 1'b0);
    idle(1);
    issue(4'd3, 4'd7, 1'b0, 1'b0);
    issue(4'd8, 4'd1, 1'b0, 1'b0);
    issue(4'd5, 4'd4, 1'b1, 1'b0);
    issue(4'd0, 4'd15, 1'b1, 1'b0);
    issue(4'd9, 4'd2, 1'b0, 1'b1);
    issue(4'd2, 4'd9, 1'b1, 1'b0);
    reset_mid(4'd6, 4'd1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
